fetch_prefetch_queue: RTL and testbench

- Parametrised next-generation instruction-fetch stage for the pipelined core.
- Replaces the fixed single-cycle fetch with a decoupled PC generator and an instruction memory request/response interface that tolerates variable latency.
- Holds fetched instructions in a DEPTH-entry prefetch queue with a valid/ready handshake toward decode.
- A branch redirect from the memory stage flushes the queue and squashes in-flight fetches.

---
 rtl/fetch_prefetch_queue.sv | 177 +++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - decoupled instruction fetch stage with prefetch queue
//
// Purpose: generates sequential fetch PCs, issues requests to a variable-latency
// instruction memory, and buffers returned instructions in a DEPTH-entry queue
// that decode drains with a valid/ready handshake. A redirect (PCSrc) flushes the
// queue and marks every in-flight fetch for silent discard.
//
// Ports:
//   CLK, resetl                      clock, asynchronous active-low reset
//   StartPC                          PC loaded when leaving the INIT cycle
//   PCSrc, TargetPC                  redirect request and target
//   imem_req_valid/ready/addr        fetch request channel (addr = currentpc)
//   imem_rsp_valid/data              in-order fetch responses, latency >= 1
//   id_valid/ready/instruction/pc    queue head toward decode
//   currentpc                        next PC to be requested
//   proto_err                        sticky: response seen with nothing outstanding
module fetch_prefetch_queue #(
  parameter int XLEN    = 64,
  parameter int ILEN    = 32,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 4
) (
  input  logic            CLK,
  input  logic            resetl,
  input  logic [XLEN-1:0] StartPC,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] TargetPC,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instruction,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] currentpc,
  output logic            proto_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]   ONE_C    = CW'(1);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
  localparam logic [PW-1:0]   ONE_P    = PW'(1);
  localparam logic [XLEN-1:0] STEP_W   = XLEN'(PC_STEP);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_currentpc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic            r_proto_err;
  logic [ILEN-1:0] r_q_data [DEPTH];
  logic [XLEN-1:0] r_q_pc   [DEPTH];

  logic            w_run;
  logic            w_redirect;
  logic [CW:0]     w_credit;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_id_valid;
  logic            w_pop;
  logic            w_rsp_drop;
  logic            w_rsp_take;
  logic            w_rsp_err;
  logic            w_push;
  logic [CW-1:0]   w_out_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ONE_P;
  endfunction

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    w_run       = (r_state == ST_RUN);
    w_redirect  = w_run && PCSrc;
    // Credit rule: a request is only issued when a queue slot is reserved for
    // its response, so a push can never find the queue full.
    w_credit    = {1'b0, r_count} + {1'b0, r_outstanding};
    w_req_valid = w_run && (w_credit < DEPTH_W) && !PCSrc;
    w_req_fire  = w_req_valid && imem_req_ready;
    w_id_valid  = (r_count != '0) && !PCSrc;
    w_pop       = w_id_valid && id_ready;
    // drop never exceeds outstanding, so the three response cases are exclusive.
    w_rsp_drop  = imem_rsp_valid && (r_drop != '0);
    w_rsp_take  = imem_rsp_valid && (r_drop == '0) && (r_outstanding != '0);
    w_rsp_err   = imem_rsp_valid && (r_drop == '0) && (r_outstanding == '0);
    // A response accepted in the redirect cycle belongs to the old stream.
    w_push      = w_rsp_take && !w_redirect;
    w_out_nxt   = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_drop || w_rsp_take);
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_currentpc   <= '0;
      r_rsp_pc      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_proto_err   <= r_proto_err | w_rsp_err;
      r_outstanding <= w_out_nxt;
      if (r_state == ST_INIT) begin
        r_currentpc <= StartPC;
        r_rsp_pc    <= StartPC;
      end else if (w_redirect) begin
        r_currentpc <= TargetPC;
        r_rsp_pc    <= TargetPC;
        r_count     <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        // Everything still in flight after this cycle is stale.
        r_drop      <= w_out_nxt;
      end else begin
        if (w_req_fire) begin
          r_currentpc <= r_currentpc + STEP_W;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + STEP_W;
          r_wr_ptr <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        if (w_rsp_drop) begin
          r_drop <= r_drop - ONE_C;
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= imem_rsp_data;
      r_q_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_currentpc;
  assign currentpc      = r_currentpc;
  assign id_valid       = w_id_valid;
  assign id_instruction = r_q_data[r_rd_ptr];
  assign id_pc          = r_q_pc[r_rd_ptr];
  assign proto_err      = r_proto_err;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - self-checking bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;
  localparam int XLEN    = 64;
  localparam int ILEN    = 32;
  localparam int DEPTH   = 4;
  localparam int PC_STEP = 4;

  logic            CLK = 1'b0;
  logic            resetl;
  logic [XLEN-1:0] StartPC;
  logic            PCSrc;
  logic [XLEN-1:0] TargetPC;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [ILEN-1:0] id_instruction;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] currentpc;
  logic            proto_err;

  fetch_prefetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .PC_STEP(PC_STEP)) dut (
    .CLK(CLK), .resetl(resetl), .StartPC(StartPC), .PCSrc(PCSrc), .TargetPC(TargetPC),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_instruction(id_instruction), .id_pc(id_pc),
    .currentpc(currentpc), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } mreq_t;

  mreq_t           memq[$];
  logic [XLEN-1:0] sb[$];
  logic [XLEN-1:0] popped[$];
  logic [XLEN-1:0] exp_req_pc;
  logic [XLEN-1:0] exp_pc;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_due = 0;
  int fires = 0;
  int lat_min = 1, lat_max = 1;
  int p_req_ready = 100, p_id_ready = 100, p_redirect = 0;
  bit force_redirect = 0;
  bit spurious = 0;
  logic [XLEN-1:0] force_target = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, XLEN'(act), XLEN'(exp));
  endtask

  // Monitor: decode-side handshakes are compared against the scoreboard.
  always @(negedge CLK) begin
    if (resetl === 1'b1) begin
      if (PCSrc) begin
        check1("redirect_id_valid", id_valid, 1'b0);
        check1("redirect_req_valid", imem_req_valid, 1'b0);
      end
      if (id_valid && id_ready) begin
        popped.push_back(id_pc);
        if (sb.size() == 0) begin
          check("unexpected_pop_pc", id_pc, ~id_pc);
        end else begin
          exp_pc = sb.pop_front();
          check("id_pc", id_pc, exp_pc);
          check("id_instruction", XLEN'(id_instruction), XLEN'(mem_word(exp_pc)));
        end
      end
    end
  end

  // One clock of stimulus: record this cycle's request/response/redirect in the
  // reference model, then drive the next cycle's inputs.
  task automatic step();
    mreq_t m;
    int    lat;
    @(negedge CLK);
    if (resetl) begin
      if (PCSrc) begin
        sb.delete();
        exp_req_pc = TargetPC;
      end
      if (imem_rsp_valid && memq.size() > 0) m = memq.pop_front();
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req_pc);
        sb.push_back(exp_req_pc);
        check1("credit_bound", sb.size() <= DEPTH, 1'b1);
        lat    = int'($urandom_range(lat_max, lat_min));
        m.addr = imem_req_addr;
        m.due  = cyc + lat;
        if (m.due <= last_due) m.due = last_due + 1;
        last_due = m.due;
        memq.push_back(m);
        exp_req_pc = exp_req_pc + XLEN'(PC_STEP);
        fires++;
      end
    end
    @(posedge CLK);
    #1;
    imem_req_ready = ($urandom_range(99) < p_req_ready);
    id_ready       = ($urandom_range(99) < p_id_ready);
    if (force_redirect) begin
      PCSrc    = 1'b1;
      TargetPC = force_target;
    end else if (p_redirect > 0 && $urandom_range(99) < p_redirect) begin
      PCSrc    = 1'b1;
      TargetPC = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                          : {$urandom, $urandom & 32'hFFFF_FFFC};
    end else begin
      PCSrc = 1'b0;
    end
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
    end else if (spurious && memq.size() == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // Asserts reset immediately, checks the reset state, releases it after one
  // edge and checks the INIT cycle.
  task automatic do_reset(input logic [XLEN-1:0] spc);
    resetl = 1'b0;
    StartPC = spc;
    PCSrc = 1'b0;
    TargetPC = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    id_ready = 1'b0;
    memq.delete();
    sb.delete();
    exp_req_pc = spc;
    #1;
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_id_valid", id_valid, 1'b0);
    check("rst_currentpc", currentpc, '0);
    check1("rst_proto_err", proto_err, 1'b0);
    @(posedge CLK);
    #1;
    last_due = cyc;
    resetl = 1'b1;
    #1;
    check1("init_req_valid", imem_req_valid, 1'b0);
  endtask

  task automatic wait_pop(input int idx, input logic [XLEN-1:0] exp, input string name);
    int n;
    n = 0;
    while (popped.size() <= idx && n < 60) begin
      step();
      n++;
    end
    check1({name, "_arrived"}, popped.size() > idx, 1'b1);
    if (popped.size() > idx) check(name, popped[idx], exp);
  endtask

  initial begin
    int p0, f0, idx, sbn;
    resetl = 1'b1;
    #3;

    // Reset release, zero-wait memory, decode always ready.
    lat_min = 1; lat_max = 1; p_req_ready = 100; p_id_ready = 100; p_redirect = 0;
    do_reset(64'h1000);
    step();
    #1;
    check1("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, 64'h1000);
    step();
    #1;
    check1("lat_t1_id_valid", id_valid, 1'b0);
    step();
    #1;
    check1("lat_t2_id_valid", id_valid, 1'b1);
    check("lat_t2_id_pc", id_pc, 64'h1000);
    p0 = popped.size();
    repeat (20) step();
    check("throughput", XLEN'(popped.size() - p0), XLEN'(20));
    check1("stream_proto_err", proto_err, 1'b0);

    // Decode stalled: exactly DEPTH requests, then drain in order.
    p_id_ready = 0;
    do_reset(64'h1000);
    f0 = fires;
    repeat (12) step();
    check("stall_fires", XLEN'(fires - f0), XLEN'(DEPTH));
    #1;
    check1("stall_req_valid", imem_req_valid, 1'b0);
    p_id_ready = 100;
    idx = popped.size();
    wait_pop(idx, 64'h1000, "drain_first");
    wait_pop(idx + 4, 64'h1010, "drain_resume");

    // Latency 3, redirect with fetches in flight.
    lat_min = 3; lat_max = 3;
    do_reset(64'h1000);
    repeat (6) step();
    force_redirect = 1; force_target = 64'h2000;
    step();
    force_redirect = 0;
    step();
    #1;
    check1("post_redirect_id_valid", id_valid, 1'b0);
    check1("post_redirect_req_valid", imem_req_valid, 1'b1);
    check("post_redirect_req_addr", imem_req_addr, 64'h2000);
    idx = popped.size();
    wait_pop(idx, 64'h2000, "redirect_first_pc");

    // Back-to-back redirects: only the latest stream survives.
    lat_min = 1; lat_max = 4;
    repeat (5) step();
    force_redirect = 1; force_target = 64'h3000;
    step();
    force_target = 64'h4000;
    step();
    force_redirect = 0;
    idx = popped.size();
    wait_pop(idx, 64'h4000, "b2b_first_pc");

    // Spurious response with nothing outstanding.
    p_req_ready = 0; p_id_ready = 0;
    repeat (8) step();
    #1;
    check1("pre_spurious_proto_err", proto_err, 1'b0);
    sbn = sb.size();
    spurious = 1;
    step();
    spurious = 0;
    step();
    #1;
    check1("spurious_proto_err", proto_err, 1'b1);
    repeat (5) step();
    check1("sticky_proto_err", proto_err, 1'b1);
    p_id_ready = 100;
    idx = popped.size();
    repeat (10) step();
    check1("spurious_queue_kept", (popped.size() - idx) >= sbn, 1'b1);

    // Reset with a full queue.
    p_req_ready = 100; p_id_ready = 0;
    repeat (12) step();
    #1;
    check1("full_before_reset", id_valid, 1'b1);
    do_reset(64'h1000);
    step();
    #1;
    check1("restart_req_valid", imem_req_valid, 1'b1);
    check("restart_req_addr", imem_req_addr, 64'h1000);

    // Randomised soak with redirects and backpressure.
    p_req_ready = 70; p_id_ready = 70; p_redirect = 4;
    repeat (3000) step();
    p_redirect = 0; p_req_ready = 0; p_id_ready = 100;
    repeat (30) step();
    check("soak_drained", XLEN'(sb.size()), '0);
    check1("soak_proto_err", proto_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
